// File: rtl/subbytes_sequencer.sv
// Streams a NUM_BYTES-byte AES state through one shared byte-wide S-box, one byte
// per cycle, collects the results and pulses done when the whole state is substituted.
module subbytes_sequencer #(
  parameter int NUM_BYTES = 16,
  parameter int SBOX_LAT  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   encrypt,
  input  logic [8*NUM_BYTES-1:0] state_in,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] state_out,
  output logic                   sbox_valid,
  output logic [7:0]             sbox_in,
  output logic                   sbox_encrypt,
  input  logic [7:0]             sbox_out,
  output logic [1:0]             dbg_state
);

  localparam int CW = $clog2(NUM_BYTES) + 1;
  localparam int IW = CW - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: sbox_valid=1 means sbox_in carries a byte this cycle; the S-box has no
  // ready and must accept every byte, returning sbox_out exactly SBOX_LAT cycles later.

  logic [1:0]             st;
  logic [8*NUM_BYTES-1:0] op;
  logic                   mode;
  logic [8*NUM_BYTES-1:0] result;
  logic [8*NUM_BYTES-1:0] result_next;
  logic [CW-1:0]          issue_cnt;
  logic [CW-1:0]          cap_cnt;
  logic                   issue_ok;
  logic                   vld_d;
  logic                   cap;
  logic                   last_cap;

  assign issue_ok     = (st == S_RUN) && (issue_cnt < CW'(NUM_BYTES));
  assign sbox_valid   = issue_ok;
  assign sbox_in      = issue_ok ? op[8*issue_cnt[IW-1:0] +: 8] : 8'h00;
  assign sbox_encrypt = mode;
  assign busy         = (st == S_RUN) || (st == S_DONE);
  assign done         = (st == S_DONE);
  assign dbg_state    = st;

  // Valid delay line matching the S-box pipeline depth.
  generate
    if (SBOX_LAT == 0) begin : g_nolat
      assign vld_d = sbox_valid;
    end else begin : g_lat
      logic [SBOX_LAT-1:0] vld_sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_sr <= '0;
        end else begin
          vld_sr[0] <= sbox_valid;
          for (int i = 1; i < SBOX_LAT; i++) vld_sr[i] <= vld_sr[i-1];
        end
      end
      assign vld_d = vld_sr[SBOX_LAT-1];
    end
  endgenerate

  assign cap      = (st == S_RUN) && vld_d;
  assign last_cap = cap && (cap_cnt == CW'(NUM_BYTES - 1));

  always_comb begin
    result_next = result;
    if (cap) result_next[8*cap_cnt[IW-1:0] +: 8] = sbox_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      op        <= '0;
      mode      <= 1'b0;
      result    <= '0;
      state_out <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (start) begin
            op        <= state_in;
            mode      <= encrypt;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            st        <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue_ok) issue_cnt <= issue_cnt + 1'b1;
          if (cap) begin
            result  <= result_next;
            cap_cnt <= cap_cnt + 1'b1;
          end
          if (last_cap) begin
            state_out <= result_next;
            st        <= S_DONE;
          end
        end
        S_DONE:  st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subbytes_sequencer.sv
// Bench for subbytes_sequencer: a combinational-S-box instance and a 2-cycle
// registered-S-box instance share stimulus; table vectors plus corner sequences.
module tb_subbytes_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         encrypt;
  logic [127:0] state_in;

  logic         busy_a, done_a, sbox_valid_a, sbox_encrypt_a;
  logic [127:0] state_out_a;
  logic [7:0]   sbox_in_a, sbox_out_a;
  logic [1:0]   dbg_state_a;

  logic         busy_b, done_b, sbox_valid_b, sbox_encrypt_b;
  logic [127:0] state_out_b;
  logic [7:0]   sbox_in_b, sbox_out_b, pipe1_b, pipe2_b;
  logic [1:0]   dbg_state_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_qa[$];
  logic [127:0] exp_qb[$];

  always #5 clk = ~clk;

  subbytes_sequencer #(.NUM_BYTES(16), .SBOX_LAT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .encrypt(encrypt), .state_in(state_in),
    .busy(busy_a), .done(done_a), .state_out(state_out_a), .sbox_valid(sbox_valid_a),
    .sbox_in(sbox_in_a), .sbox_encrypt(sbox_encrypt_a), .sbox_out(sbox_out_a),
    .dbg_state(dbg_state_a)
  );

  subbytes_sequencer #(.NUM_BYTES(16), .SBOX_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .encrypt(encrypt), .state_in(state_in),
    .busy(busy_b), .done(done_b), .state_out(state_out_b), .sbox_valid(sbox_valid_b),
    .sbox_in(sbox_in_b), .sbox_encrypt(sbox_encrypt_b), .sbox_out(sbox_out_b),
    .dbg_state(dbg_state_b)
  );

  // Reference S-box built from GF(2^8) inversion and the affine maps.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i < 256; i++)
      if (x != 8'h00 && gmul(x, 8'(i)) == 8'h01) r = 8'(i);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x, input logic enc);
    logic [7:0] b;
    if (enc) begin
      b = ginv(x);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    b = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
    return ginv(b);
  endfunction

  always_comb sbox_out_a = sbox_model(sbox_in_a, sbox_encrypt_a);

  always_ff @(posedge clk) begin
    pipe1_b <= sbox_model(sbox_in_b, sbox_encrypt_b);
    pipe2_b <= pipe1_b;
  end
  assign sbox_out_b = pipe2_b;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each done must match the oldest outstanding expected result.
  task automatic sb_done_a();
    if (exp_qa.size() == 0) check("unexpected_done_a", 128'd1, 128'd0);
    else check("state_out_a", state_out_a, exp_qa.pop_front());
  endtask

  task automatic sb_done_b();
    if (exp_qb.size() == 0) check("unexpected_done_b", 128'd1, 128'd0);
    else check("state_out_b", state_out_b, exp_qb.pop_front());
  endtask

  // One operation; optionally pulses start and flips inputs mid-RUN.
  task automatic run_op(input logic enc, input logic [127:0] din, input logic [127:0] dout,
                        input bit disturb);
    int da, db, na, nb, ebusy, evld, emode;
    da = 0; db = 0; na = 0; nb = 0; ebusy = 0; evld = 0; emode = 0;
    @(negedge clk);
    start = 1'b1; encrypt = enc; state_in = din;
    exp_qa.push_back(dout);
    exp_qb.push_back(dout);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (done_a) begin na++; da = k; sb_done_a(); end
      if (done_b) begin nb++; db = k; sb_done_b(); end
      if (busy_a !== (k <= 17)) ebusy++;
      if (busy_b !== (k <= 19)) ebusy++;
      if (sbox_valid_a !== (k <= 16)) evld++;
      if (sbox_valid_b !== (k <= 16)) evld++;
      if (sbox_valid_a && sbox_encrypt_a !== enc) emode++;
      if (sbox_valid_b && sbox_encrypt_b !== enc) emode++;
      if (disturb && k == 5) begin start = 1'b1; encrypt = ~enc; state_in = ~din; end
      if (disturb && k == 6) begin start = 1'b0; encrypt = enc; end
      @(negedge clk);
    end
    check("done_cycle_a", 128'(da), 128'd17);
    check("done_count_a", 128'(na), 128'd1);
    check("done_cycle_b", 128'(db), 128'd19);
    check("done_count_b", 128'(nb), 128'd1);
    check("busy_profile", 128'(ebusy), 128'd0);
    check("valid_profile", 128'(evld), 128'd0);
    check("latched_mode", 128'(emode), 128'd0);
  endtask

  typedef struct {
    logic         enc;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int da1, da2, db1, db2, na, nb;
    vecs[0] = '{1'b1, 128'h0, {16{8'h63}}};
    vecs[1] = '{1'b0, {16{8'h63}}, 128'h0};
    vecs[2] = '{1'b1, 128'h0f0e0d0c0b0a09080706050403020100,
                128'h76abd7fe2b670130c56f6bf27b777c63};
    vecs[3] = '{1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63,
                128'h0f0e0d0c0b0a09080706050403020100};
    vecs[4] = '{1'b0, 128'h0, {16{8'h52}}};
    vecs[5] = '{1'b1, {16{8'h53}}, {16{8'hed}}};

    rst = 1'b1; start = 1'b0; encrypt = 1'b0; state_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 128'({busy_a, busy_b}), 128'd0);
    check("reset_done", 128'({done_a, done_b}), 128'd0);
    check("reset_state_out_a", state_out_a, 128'd0);
    check("reset_state_out_b", state_out_b, 128'd0);
    check("reset_sbox_valid", 128'({sbox_valid_a, sbox_valid_b}), 128'd0);
    check("reset_sbox_in", 128'({sbox_in_a, sbox_in_b}), 128'd0);
    check("reset_sbox_encrypt", 128'({sbox_encrypt_a, sbox_encrypt_b}), 128'd0);
    check("reset_dbg_state", 128'({dbg_state_a, dbg_state_b}), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_op(vecs[v].enc, vecs[v].din, vecs[v].dout, 1'b0);

    // Mid-op start pulse and mode toggle are ignored.
    run_op(vecs[2].enc, vecs[2].din, vecs[2].dout, 1'b1);

    // Back-to-back: start held high until both instances have accepted a second op.
    da1 = 0; da2 = 0; db1 = 0; db2 = 0; na = 0; nb = 0;
    @(negedge clk);
    start = 1'b1; encrypt = vecs[5].enc; state_in = vecs[5].din;
    repeat (2) begin exp_qa.push_back(vecs[5].dout); exp_qb.push_back(vecs[5].dout); end
    @(negedge clk);
    for (int k = 1; k <= 45; k++) begin
      if (done_a) begin na++; if (na == 1) da1 = k; else da2 = k; sb_done_a(); end
      if (done_b) begin nb++; if (nb == 1) db1 = k; else db2 = k; sb_done_b(); end
      if (k == 18) check("b2b_idle_gap_a", 128'(busy_a), 128'd0);
      if (k == 19) check("b2b_restart_a", 128'(busy_a), 128'd1);
      if (k == 21) start = 1'b0;
      @(negedge clk);
    end
    check("b2b_done_a", 128'({da1, da2}), 128'({32'd17, 32'd35}));
    check("b2b_done_b", 128'({db1, db2}), 128'({32'd19, 32'd39}));
    check("b2b_count", 128'({na, nb}), 128'({32'd2, 32'd2}));

    // Reset mid-operation aborts and clears state_out.
    @(negedge clk);
    start = 1'b1; encrypt = vecs[0].enc; state_in = vecs[0].din;
    @(negedge clk);
    start = 1'b0;
    na = 0;
    for (int k = 1; k <= 8; k++) begin
      if (done_a || done_b) na++;
      if (k == 8) rst = 1'b1;
      @(negedge clk);
    end
    check("abort_busy", 128'({busy_a, busy_b}), 128'd0);
    check("abort_state_out_a", state_out_a, 128'd0);
    check("abort_state_out_b", state_out_b, 128'd0);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (done_a || done_b) na++;
      @(negedge clk);
    end
    check("abort_no_done", 128'(na), 128'd0);
    run_op(vecs[3].enc, vecs[3].din, vecs[3].dout, 1'b0);

    check("scoreboard_drained", 128'({exp_qa.size(), exp_qb.size()}), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
